// File: rtl/vga_pkg.sv
//----------------------------------------------------------------------------
// vga_pkg : key roles, debounce state encoding and sizing helpers shared by
//           the key front-end and the picture stage.         Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int KEY_NEXT      = 0;
  localparam int KEY_PREV      = 1;
  localparam int KEY_HOME      = 2;
  localparam int KEY_FRZ       = 3;

  localparam int DEF_NUM_MODES = 4;

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_FILT_DN = 2'd1,
    S_DOWN    = 2'd2,
    S_FILT_UP = 2'd3
  } key_state_e;

  // Counter must hold the largest cycle count it is ever compared against.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_filter_ch.sv
//----------------------------------------------------------------------------
// key_filter_ch : one key channel - 2-flop sync, debounce FSM, press/release
//                 pulses, optional auto-repeat (KEY_AUTOREPEAT_EN). Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module key_filter_ch
  import vga_pkg::*;
#(
  parameter int KEY_ACT_LOW  = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
`ifdef KEY_AUTOREPEAT_EN
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000,
  parameter bit REPEAT_EN    = 1'b1,
`endif
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic             REL_LVL  = (KEY_ACT_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REARM     = CNT_W'(HOLD_CYC - REPEAT_CYC);
`endif

  logic [1:0]       sync_q;
  logic             pressed;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
`ifdef KEY_AUTOREPEAT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {2{REL_LVL}};
    end else begin
      sync_q <= {sync_q[0], key_pin_i};
    end
  end

  assign pressed = sync_q[1] ^ REL_LVL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_UP: begin
        if (pressed) begin
          state_d = S_FILT_DN;
          cnt_d   = CNT_ONE;
        end
      end
      S_FILT_DN: begin
        if (!pressed) begin
          state_d = S_UP;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_DOWN;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DOWN: begin
        if (!pressed) begin
          state_d = S_FILT_UP;
          cnt_d   = CNT_ONE;
        end
      end
      S_FILT_UP: begin
        if (pressed) begin
          state_d = S_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = S_UP;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_UP;
        cnt_d   = '0;
      end
    endcase

`ifdef KEY_AUTOREPEAT_EN
    // Re-arm below the hold threshold so later repeats come every REPEAT_CYC.
    hold_d = '0;
    if (REPEAT_EN && (state_q == S_DOWN) && pressed) begin
      if (hold_q == HOLD_LAST) begin
        hold_d  = REARM;
        press_d = 1'b1;
      end else begin
        hold_d = hold_q + CNT_ONE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
//----------------------------------------------------------------------------
// key_debounce : debounced key front-end plus display-mode / freeze registers
//                for vga_pic. Option macro: KEY_AUTOREPEAT_EN.   Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import vga_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int KEY_ACT_LOW  = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int NUM_MODES    = DEF_NUM_MODES,
  parameter int MODE_W       = 2,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] keyin,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [MODE_W-1:0]   mode,
  output logic                freeze
);

  localparam int              CNT_W     = cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              freeze_q, freeze_d;

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
      key_filter_ch #(
        .KEY_ACT_LOW  (KEY_ACT_LOW),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
`ifdef KEY_AUTOREPEAT_EN
        .HOLD_CYC     (HOLD_CYC),
        .REPEAT_CYC   (REPEAT_CYC),
        .REPEAT_EN    ((k != KEY_HOME) && (k != KEY_FRZ)),
`endif
        .CNT_W        (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rstn      (rstn),
        .key_pin_i (keyin[k]),
        .level_o   (key_level[k]),
        .press_o   (key_press[k]),
        .release_o (key_release[k])
      );
    end
  endgenerate

  // HOME wins; NEXT and PREV together cancel out.
  always_comb begin
    mode_d   = mode_q;
    freeze_d = freeze_q ^ key_press[KEY_FRZ];
    if (key_press[KEY_HOME]) begin
      mode_d = '0;
    end else if (key_press[KEY_NEXT] && !key_press[KEY_PREV]) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_ONE;
    end else if (key_press[KEY_PREV] && !key_press[KEY_NEXT]) begin
      mode_d = (mode_q == '0) ? MODE_LAST : mode_q - MODE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= '0;
      freeze_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      freeze_q <= freeze_d;
    end
  end

  assign mode   = mode_q;
  assign freeze = freeze_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
//----------------------------------------------------------------------------
// tb_key_debounce : directed + random stimulus against a behavioural model of
//                   the key front-end (DEBOUNCE 8, HOLD 40, REPEAT 10). Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

  localparam int DC = 8;
  localparam int HC = 40;
  localparam int RC = 10;
  localparam int NM = 4;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic [3:0] keyin = 4'hF;
  logic [3:0] key_level, key_press, key_release;
  logic [1:0] mode;
  logic       freeze;

  int vectors     = 0;
  int miscompares = 0;
  int npress[4];
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS     (4),
    .KEY_ACT_LOW  (1),
    .DEBOUNCE_CYC (DC),
    .NUM_MODES    (NM),
    .MODE_W       (2),
    .HOLD_CYC     (HC),
    .REPEAT_CYC   (RC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .keyin       (keyin),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .mode        (mode),
    .freeze      (freeze)
  );

  // Model: a level flips after DC consecutive sampled cycles disagreeing with it.
  logic [3:0] m_ph1, m_ph2, m_lvl, m_press, m_rel, m_pprev;
  int         m_run[4];
  int         m_hold[4];
  int         m_mode;
  bit         m_frz;

  function automatic void model_reset();
    m_ph1 = 4'hF; m_ph2 = 4'hF; m_lvl = '0; m_press = '0; m_rel = '0; m_pprev = '0;
    m_mode = 0; m_frz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_run[k] = 0; m_hold[k] = 0;
    end
  endfunction

  function automatic void model_step();
    logic [3:0] prs, rel;
    prs = '0; rel = '0;
    if (m_pprev[2])                     m_mode = 0;
    else if (m_pprev[0] && !m_pprev[1]) m_mode = (m_mode + 1) % NM;
    else if (m_pprev[1] && !m_pprev[0]) m_mode = (m_mode + NM - 1) % NM;
    if (m_pprev[3]) m_frz = !m_frz;
    for (int k = 0; k < 4; k++) begin
      bit s, in_down;
      s       = !m_ph2[k];
      m_ph2[k] = m_ph1[k];
      m_ph1[k] = keyin[k];
      in_down = m_lvl[k] && (m_run[k] == 0) && s;
      if (s != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DC) begin
          m_lvl[k] = s;
          m_run[k] = 0;
          if (s) prs[k] = 1'b1;
          else   rel[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
`ifdef KEY_AUTOREPEAT_EN
      if (in_down && k < 2) begin
        m_hold[k]++;
        if (m_hold[k] >= HC && ((m_hold[k] - HC) % RC) == 0) prs[k] = 1'b1;
      end else begin
        m_hold[k] = 0;
      end
`else
      if (in_down) m_hold[k] = 0;
`endif
    end
    m_press = prs;
    m_rel   = rel;
    m_pprev = prs;
  endfunction

  always @(posedge clk) begin
    if (!rstn) model_reset();
    else       model_step();
    #1;
    for (int k = 0; k < 4; k++) if (key_press[k] === 1'b1) npress[k]++;
    if (chk_en) begin
      vectors++;
      if ({key_level, key_press, key_release, mode, freeze} !==
          {m_lvl, m_press, m_rel, 2'(m_mode), m_frz}) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: dut lvl=%b prs=%b rel=%b mode=%0d frz=%b, model lvl=%b prs=%b rel=%b mode=%0d frz=%b",
                 $time, key_level, key_press, key_release, mode, freeze,
                 m_lvl, m_press, m_rel, m_mode, m_frz);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press_keys(input logic [3:0] mask, input int hold, input int idle);
    @(negedge clk) keyin = keyin & ~mask;
    repeat (hold) @(negedge clk);
    keyin = keyin | mask;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int lat, n0;
    int pos[$];
    for (int k = 0; k < 4; k++) npress[k] = 0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({key_level, key_press, key_release, mode, freeze}), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // clean press on key0
    n0 = npress[0];
    lat = 0;
    @(negedge clk) keyin[0] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #2;
      if (key_level[0] && lat == 0) lat = i;
    end
    @(negedge clk) keyin[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("press_latency", lat, 10);
    check("press_count", npress[0] - n0, 1);
    check("press_mode", int'(mode), 1);

    // bounce on key1
    n0 = npress[1];
    @(negedge clk) keyin[1] = 1'b0;
    repeat (5) @(negedge clk);
    keyin[1] = 1'b1;
    repeat (2) @(negedge clk);
    keyin[1] = 1'b0;
    repeat (5) @(negedge clk);
    keyin[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_pulses", npress[1] - n0, 0);
    check("bounce_level", int'(key_level[1]), 0);
    check("bounce_mode", int'(mode), 1);

    // wrap
    press_keys(4'b0100, 20, 20);
    check("home_mode", int'(mode), 0);
    press_keys(4'b0010, 20, 20);
    check("wrap_down", int'(mode), 3);
    for (int i = 0; i < 4; i++) begin
      press_keys(4'b0001, 20, 20);
      check("wrap_up", int'(mode), i);
    end

    // priority
    press_keys(4'b0010, 20, 20);
    check("prio_setup", int'(mode), 2);
    press_keys(4'b0101, 20, 20);
    check("prio_home_next", int'(mode), 0);
    press_keys(4'b0001, 20, 20);
    press_keys(4'b0001, 20, 20);
    press_keys(4'b0011, 20, 20);
    check("prio_next_prev", int'(mode), 2);

    // freeze and release timing
    @(negedge clk) keyin[3] = 1'b0;
    repeat (20) @(negedge clk);
    check("freeze_set", int'(freeze), 1);
    lat = 0;
    keyin[3] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #2;
      if (key_release[3] && lat == 0) lat = i;
    end
    check("release_latency", lat, 10);
    check("freeze_hold", int'(freeze), 1);

    // reset in the middle of filtering
    @(negedge clk) keyin[0] = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_reset", int'({key_level, key_press, key_release, mode, freeze}), 0);
    keyin = 4'hF;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    n0 = npress[0] + npress[1] + npress[2] + npress[3];
    repeat (25) @(negedge clk);
    check("post_reset_pulses", npress[0] + npress[1] + npress[2] + npress[3] - n0, 0);
    check("post_reset_level", int'(key_level), 0);

    // long hold on key0
    @(negedge clk) keyin[0] = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #2;
      if (key_press[0]) pos.push_back(i);
      @(negedge clk);
      if (i == 80) keyin[0] = 1'b1;
    end
`ifdef KEY_AUTOREPEAT_EN
    check("hold_pulses", pos.size(), 5);
    if (pos.size() == 5) begin
      check("hold_first", pos[0], 10);
      check("hold_rep1", pos[1] - pos[0], 40);
      check("hold_rep4", pos[4] - pos[0], 70);
    end
    check("hold_mode", int'(mode), 1);
`else
    check("hold_pulses", pos.size(), 1);
    if (pos.size() == 1) check("hold_first", pos[0], 10);
    check("hold_mode", int'(mode), 1);
`endif

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, ((c / 500) % 2 == 0) ? 11 : 40) == 0) keyin[k] = ~keyin[k];
      if ($urandom_range(0, 1999) == 0) begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
    end
    keyin = 4'hF;
    repeat (60) @(negedge clk);
    check("final_level", int'(key_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
